idex_operand_stage: RTL



---
 rtl/idex_operand_stage.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/idex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded instructions, forwards
// MEM/WB results onto the operands and inserts a single bubble on load-use.
module idex_operand_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RA_W  = 5,
    parameter int unsigned AOP_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [RA_W-1:0]  id_rs1_addr_i,
    input  logic [RA_W-1:0]  id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [XLEN-1:0]  id_datars1_i,
    input  logic [XLEN-1:0]  id_datars2_i,
    input  logic [XLEN-1:0]  id_imm_i,
    input  logic             id_use_imm_i,
    input  logic [RA_W-1:0]  id_rd_addr_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_memwrite_i,
    input  logic [AOP_W-1:0] id_aluop_i,
    input  logic [RA_W-1:0]  mem_rd_addr_i,
    input  logic             mem_regwrite_i,
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic [RA_W-1:0]  wb_rd_addr_i,
    input  logic             wb_regwrite_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             mem_stall_i,
    input  logic             ex_flush_i,
    output logic [XLEN-1:0]  rr_datars1_o,
    output logic [XLEN-1:0]  rr_datars2_o,
    output logic [XLEN-1:0]  ex_store_data_o,
    output logic [AOP_W-1:0] ctrl_aluop_o,
    output logic [RA_W-1:0]  ex_rd_addr_o,
    output logic             ex_regwrite_o,
    output logic             ex_memread_o,
    output logic             ex_memwrite_o,
    output logic             ex_valid_o,
    output logic             id_stall_o
);

    typedef struct packed {
        logic             valid;
        logic [RA_W-1:0]  rs1_addr;
        logic [RA_W-1:0]  rs2_addr;
        logic             rs1_used;
        logic             rs2_used;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic             use_imm;
        logic [RA_W-1:0]  rd;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic [AOP_W-1:0] aluop;
    } stage_t;

    stage_t ex_q;
    stage_t ex_d;
    stage_t id_cap;
    logic   wb_hit_rs1;
    logic   wb_hit_rs2;
    logic   load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // Register file is not write-through, so catch the value being written this cycle.
    assign wb_hit_rs1 = wb_regwrite_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs1_addr_i);
    assign wb_hit_rs2 = wb_regwrite_i && (wb_rd_addr_i != '0) && (wb_rd_addr_i == id_rs2_addr_i);

    always_comb begin
        id_cap          = '0;
        id_cap.valid    = 1'b1;
        id_cap.rs1_addr = id_rs1_addr_i;
        id_cap.rs2_addr = id_rs2_addr_i;
        id_cap.rs1_used = id_rs1_used_i;
        id_cap.rs2_used = id_rs2_used_i;
        id_cap.rs1_data = wb_hit_rs1 ? wb_data_i : id_datars1_i;
        id_cap.rs2_data = wb_hit_rs2 ? wb_data_i : id_datars2_i;
        id_cap.imm      = id_imm_i;
        id_cap.use_imm  = id_use_imm_i;
        id_cap.rd       = id_rd_addr_i;
        id_cap.regwrite = id_regwrite_i;
        id_cap.memread  = id_memread_i;
        id_cap.memwrite = id_memwrite_i;
        id_cap.aluop    = id_aluop_i;
    end

    // A load in EX cannot forward yet; hold decode for one cycle.
    assign load_use = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid_i &&
                      ((id_rs1_used_i && (id_rs1_addr_i == ex_q.rd)) ||
                       (id_rs2_used_i && (id_rs2_addr_i == ex_q.rd)));
    assign id_stall_o = load_use && !ex_flush_i;

    // Flush beats stall, stall beats hazard bubble, otherwise capture decode.
    always_comb begin
        ex_d = ex_q;
        if (ex_flush_i) begin
            ex_d = '0;
        end else if (mem_stall_i) begin
            ex_d = ex_q;
        end else if (id_stall_o || !id_valid_i) begin
            ex_d = '0;
        end else begin
            ex_d = id_cap;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // MEM result is younger than WB, so it wins; x0 never forwards.
    function automatic logic [XLEN-1:0] forward(input logic            used,
                                                input logic [RA_W-1:0] rs,
                                                input logic [XLEN-1:0] raw);
        logic [XLEN-1:0] val;
        val = raw;
        if (used && (rs != '0)) begin
            if (mem_regwrite_i && (mem_rd_addr_i == rs)) begin
                val = mem_data_i;
            end else if (wb_regwrite_i && (wb_rd_addr_i == rs)) begin
                val = wb_data_i;
            end
        end
        return val;
    endfunction

    assign fwd_rs1 = forward(ex_q.rs1_used, ex_q.rs1_addr, ex_q.rs1_data);
    assign fwd_rs2 = forward(ex_q.rs2_used, ex_q.rs2_addr, ex_q.rs2_data);

    assign rr_datars1_o    = fwd_rs1;
    assign rr_datars2_o    = ex_q.use_imm ? ex_q.imm : fwd_rs2;
    assign ex_store_data_o = fwd_rs2;
    assign ctrl_aluop_o    = ex_q.aluop;
    assign ex_rd_addr_o    = ex_q.rd;
    assign ex_regwrite_o   = ex_q.regwrite;
    assign ex_memread_o    = ex_q.memread;
    assign ex_memwrite_o   = ex_q.memwrite;
    assign ex_valid_o      = ex_q.valid;

endmodule
